// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store sequencer: FSM states, d_mode encodings,
// byte-enable, store-replication and alignment checks.
package lsu_pkg;

    typedef enum logic [2:0] {StIdle, StReq, StResp, StDone, StErr} lsu_state_e;

    localparam logic [2:0] DM_W  = 3'd0;
    localparam logic [2:0] DM_H  = 3'd1;
    localparam logic [2:0] DM_B  = 3'd2;
    localparam logic [2:0] DM_HU = 3'd3;
    localparam logic [2:0] DM_BU = 3'd4;

    function automatic logic is_half(input logic [2:0] mode);
        return (mode == DM_H) || (mode == DM_HU);
    endfunction

    function automatic logic is_byte(input logic [2:0] mode);
        return (mode == DM_B) || (mode == DM_BU);
    endfunction

    // Modes 5-7 fall through to word width.
    function automatic logic [3:0] byte_en(input logic [2:0] mode, input logic [1:0] off);
        if (is_byte(mode)) return 4'b0001 << off;
        if (is_half(mode)) return 4'b0011 << {off[1], 1'b0};
        return 4'b1111;
    endfunction

    function automatic logic [31:0] store_rep(input logic [2:0] mode, input logic [31:0] data);
        if (is_byte(mode)) return {4{data[7:0]}};
        if (is_half(mode)) return {2{data[15:0]}};
        return data;
    endfunction

    function automatic logic misaligned(input logic [2:0] mode, input logic [1:0] off);
        if (is_byte(mode)) return 1'b0;
        if (is_half(mode)) return off[0];
        return off != 2'b00;
    endfunction

endpackage

// File: rtl/lsu_sequencer_if.sv
// Handshaked data-memory port between the load/store sequencer and data memory.
interface lsu_sequencer_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ready, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ready, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Shifts the addressed lane of a read word down to bit 0 and sign/zero extends per d_mode.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  d_mode,
    output logic [31:0] result
);
    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (d_mode)
            DM_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            DM_BU:   result = {24'h0, shifted[7:0]};
            DM_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            DM_HU:   result = {16'h0, shifted[15:0]};
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/lsu_sequencer.sv
// Multi-cycle load/store sequencer: stalls the core while a data-memory access is outstanding,
// formats store data and byte enables, aligns load data, and flags misalignment and timeouts.
module lsu_sequencer
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_op_valid,
    input  logic                  memwen,
    input  logic [2:0]            d_mode,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  stall,
    output logic [31:0]           ld_data,
    output logic                  ld_valid,
    output logic                  misalign,
    output logic                  bus_err,
    lsu_sequencer_if.master       dmem
);
    lsu_state_e state_q;
    logic [CNT_W-1:0] cnt_q;
    logic        we_q;
    logic [2:0]  mode_q;
    logic [1:0]  off_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        req_q;
    logic [31:0] ld_data_q;
    logic        ld_valid_q;
    logic        misalign_q;
    logic        bus_err_q;
    logic [31:0] ld_ext;
    logic        timeout_hit;

    lsu_load_align u_load_align (
        .rdata  (dmem.dmem_rdata),
        .offset (off_q),
        .d_mode (mode_q),
        .result (ld_ext)
    );

    // Last counted cycle: the increment would reach TIMEOUT_CYCLES.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            mode_q     <= DM_W;
            off_q      <= 2'b00;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            req_q      <= 1'b0;
            ld_data_q  <= '0;
            ld_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            ld_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (mem_op_valid) begin
                        we_q    <= memwen;
                        mode_q  <= d_mode;
                        off_q   <= addr[1:0];
                        addr_q  <= {addr[31:2], 2'b00};
                        be_q    <= byte_en(d_mode, addr[1:0]);
                        wdata_q <= store_rep(d_mode, wdata);
                        cnt_q   <= '0;
                        if (misaligned(d_mode, addr[1:0])) begin
                            misalign_q <= 1'b1;
                            state_q    <= StErr;
                        end else begin
                            req_q   <= 1'b1;
                            state_q <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (dmem.dmem_ready) begin
                        req_q <= 1'b0;
                        if (we_q) begin
                            state_q <= StDone;
                        end else if (dmem.dmem_rvalid) begin
                            ld_data_q  <= ld_ext;
                            ld_valid_q <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            state_q <= StResp;
                        end
                    end else if (timeout_hit) begin
                        req_q     <= 1'b0;
                        bus_err_q <= 1'b1;
                        state_q   <= StErr;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    if (dmem.dmem_rvalid) begin
                        ld_data_q  <= ld_ext;
                        ld_valid_q <= 1'b1;
                        state_q    <= StDone;
                    end else if (timeout_hit) begin
                        bus_err_q <= 1'b1;
                        state_q   <= StErr;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        stall = 1'b0;
        case (state_q)
            StIdle:        stall = mem_op_valid;
            StReq, StResp: stall = 1'b1;
            default:       stall = 1'b0;
        endcase
    end

    assign ld_data         = ld_data_q;
    assign ld_valid        = ld_valid_q;
    assign misalign        = misalign_q;
    assign bus_err         = bus_err_q;
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;
endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer: stores, loads, misalignment, timeout and mid-access reset.
module tb_lsu_sequencer;
    logic        clk;
    logic        rst_n;
    logic        mem_op_valid;
    logic        memwen;
    logic [2:0]  d_mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        misalign;
    logic        bus_err;
    int          checks;
    int          errors;

    lsu_sequencer_if bus ();

    lsu_sequencer #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_op_valid (mem_op_valid),
        .memwen       (memwen),
        .d_mode       (d_mode),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .ld_data      (ld_data),
        .ld_valid     (ld_valid),
        .misalign     (misalign),
        .bus_err      (bus_err),
        .dmem         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an op in IDLE on a negedge and check the combinational stall.
    task automatic present(input logic we, input logic [2:0] mode, input logic [31:0] a,
                           input logic [31:0] d, input string name);
        @(negedge clk);
        mem_op_valid = 1'b1; memwen = we; d_mode = mode; addr = a; wdata = d;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL %s_idle_stall: got %b want 1", name, stall);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_op_valid = 1'b0; memwen = 1'b0; d_mode = 3'd0;
        addr = '0; wdata = '0;
        bus.dmem_ready = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
        #12;
        checks++;
        if ({stall, ld_valid, misalign, bus_err, bus.dmem_req} !== 5'b0 || ld_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got st=%b lv=%b ma=%b be=%b rq=%b ld=%h want all 0",
                     stall, ld_valid, misalign, bus_err, bus.dmem_req, ld_data);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_store_word();
        present(1'b1, 3'd0, 32'h0000_0100, 32'hDEAD_BEEF, "sw");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_op_valid = 1'b0; addr = 32'hFFFF_FFFF; wdata = '0;
            checks++;
            if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1 || bus.dmem_addr !== 32'h100 ||
                bus.dmem_be !== 4'b1111 || bus.dmem_wdata !== 32'hDEAD_BEEF || stall !== 1'b1) begin
                errors++;
                $display("FAIL sw_req_stable[%0d]: got rq=%b we=%b a=%h be=%b wd=%h st=%b want 1 1 100 1111 deadbeef 1",
                         i, bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata, stall);
            end
            bus.dmem_ready = (i == 2);
        end
        @(negedge clk); bus.dmem_ready = 1'b0;
        checks++;
        if (stall !== 1'b0 || ld_valid !== 1'b0 || bus.dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL sw_done: got st=%b lv=%b rq=%b want 0 0 0", stall, ld_valid, bus.dmem_req);
        end
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || bus.dmem_req !== 1'b0) begin
            errors++; $display("FAIL sw_idle_after: got st=%b rq=%b want 0 0", stall, bus.dmem_req);
        end
    endtask

    // Accept in REQ, return data one cycle later from RESP.
    task automatic test_load_resp(input logic [2:0] mode, input logic [31:0] a,
                                  input logic [31:0] rd, input logic [31:0] exp, input string name);
        present(1'b0, mode, a, 32'h0, name);
        @(negedge clk); mem_op_valid = 1'b0; bus.dmem_ready = 1'b1;
        @(negedge clk); bus.dmem_ready = 1'b0;
        checks++;
        if (bus.dmem_req !== 1'b0 || stall !== 1'b1) begin
            errors++; $display("FAIL %s_resp: got rq=%b st=%b want 0 1", name, bus.dmem_req, stall);
        end
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = rd;
        @(negedge clk); bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
        checks++;
        if (ld_valid !== 1'b1 || ld_data !== exp || stall !== 1'b0) begin
            errors++; $display("FAIL %s_done: got lv=%b ld=%h st=%b want 1 %h 0",
                               name, ld_valid, ld_data, stall, exp);
        end
        @(negedge clk);
        checks++;
        if (ld_valid !== 1'b0) begin
            errors++; $display("FAIL %s_pulse: got lv=%b want 0", name, ld_valid);
        end
    endtask

    // ready and rvalid together in REQ: straight to DONE.
    task automatic test_load_fast(input logic [2:0] mode, input logic [31:0] a,
                                  input logic [31:0] rd, input logic [31:0] exp, input string name);
        present(1'b0, mode, a, 32'h0, name);
        @(negedge clk); mem_op_valid = 1'b0;
        bus.dmem_ready = 1'b1; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = rd;
        @(negedge clk);
        bus.dmem_ready = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
        checks++;
        if (ld_valid !== 1'b1 || ld_data !== exp || stall !== 1'b0 || bus.dmem_req !== 1'b0) begin
            errors++; $display("FAIL %s_fast: got lv=%b ld=%h st=%b rq=%b want 1 %h 0 0",
                               name, ld_valid, ld_data, stall, bus.dmem_req, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_store(input logic [2:0] mode, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] exp_a, input logic [3:0] exp_be,
                              input logic [31:0] exp_wd, input string name);
        present(1'b1, mode, a, d, name);
        @(negedge clk); mem_op_valid = 1'b0;
        checks++;
        if (bus.dmem_req !== 1'b1 || bus.dmem_addr !== exp_a || bus.dmem_be !== exp_be ||
            bus.dmem_wdata !== exp_wd) begin
            errors++; $display("FAIL %s_req: got rq=%b a=%h be=%b wd=%h want 1 %h %b %h", name,
                               bus.dmem_req, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata,
                               exp_a, exp_be, exp_wd);
        end
        bus.dmem_ready = 1'b1;
        @(negedge clk); bus.dmem_ready = 1'b0;
        checks++;
        if (stall !== 1'b0 || ld_valid !== 1'b0) begin
            errors++; $display("FAIL %s_done: got st=%b lv=%b want 0 0", name, stall, ld_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_misalign(input logic we, input logic [2:0] mode, input logic [31:0] a,
                                 input string name);
        present(we, mode, a, 32'h5555_5555, name);
        @(negedge clk); mem_op_valid = 1'b0;
        checks++;
        if (misalign !== 1'b1 || bus.dmem_req !== 1'b0 || ld_valid !== 1'b0 || stall !== 1'b0 ||
            bus_err !== 1'b0) begin
            errors++; $display("FAIL %s_err: got ma=%b rq=%b lv=%b st=%b be=%b want 1 0 0 0 0",
                               name, misalign, bus.dmem_req, ld_valid, stall, bus_err);
        end
        @(negedge clk);
        checks++;
        if (misalign !== 1'b0 || stall !== 1'b0 || bus.dmem_req !== 1'b0) begin
            errors++; $display("FAIL %s_idle: got ma=%b st=%b rq=%b want 0 0 0",
                               name, misalign, stall, bus.dmem_req);
        end
    endtask

    task automatic test_timeout();
        present(1'b0, 3'd0, 32'h0000_0400, 32'h0, "tmo");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_op_valid = 1'b0;
            checks++;
            if (bus.dmem_req !== 1'b1 || bus_err !== 1'b0 || stall !== 1'b1) begin
                errors++; $display("FAIL tmo_req[%0d]: got rq=%b be=%b st=%b want 1 0 1",
                                   i, bus.dmem_req, bus_err, stall);
            end
        end
        @(negedge clk);
        checks++;
        if (bus_err !== 1'b1 || bus.dmem_req !== 1'b0 || stall !== 1'b0 || ld_valid !== 1'b0) begin
            errors++; $display("FAIL tmo_err: got be=%b rq=%b st=%b lv=%b want 1 0 0 0",
                               bus_err, bus.dmem_req, stall, ld_valid);
        end
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h1234_5678;
        @(negedge clk); bus.dmem_rvalid = 1'b0;
        checks++;
        if (bus_err !== 1'b0 || ld_valid !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL tmo_idle: got be=%b lv=%b st=%b want 0 0 0",
                               bus_err, ld_valid, stall);
        end
    endtask

    task automatic test_reset_mid();
        present(1'b0, 3'd0, 32'h0000_0500, 32'h0, "rstm");
        @(negedge clk); mem_op_valid = 1'b0; bus.dmem_ready = 1'b1;
        @(negedge clk); bus.dmem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.dmem_req !== 1'b0 || stall !== 1'b0 || ld_data !== 32'h0 || ld_valid !== 1'b0 ||
            misalign !== 1'b0 || bus_err !== 1'b0) begin
            errors++; $display("FAIL rstm_clear: got rq=%b st=%b ld=%h lv=%b ma=%b be=%b want 0 0 0 0 0 0",
                               bus.dmem_req, stall, ld_data, ld_valid, misalign, bus_err);
        end
        @(negedge clk); rst_n = 1'b1; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk); bus.dmem_rvalid = 1'b0;
        checks++;
        if (ld_valid !== 1'b0 || stall !== 1'b0 || bus.dmem_req !== 1'b0 || ld_data !== 32'h0) begin
            errors++; $display("FAIL rstm_idle: got lv=%b st=%b rq=%b ld=%h want 0 0 0 0",
                               ld_valid, stall, bus.dmem_req, ld_data);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_store_word();
        test_load_resp(3'd2, 32'h0000_0203, 32'h80FF_1234, 32'hFFFF_FF80, "lb");
        test_load_resp(3'd4, 32'h0000_0203, 32'h80FF_1234, 32'h0000_0080, "lbu");
        test_load_fast(3'd1, 32'h0000_0102, 32'h8001_7FFF, 32'hFFFF_8001, "lh");
        test_load_fast(3'd3, 32'h0000_0102, 32'h8001_7FFF, 32'h0000_8001, "lhu");
        test_load_fast(3'd0, 32'h0000_0104, 32'hCAFE_F00D, 32'hCAFE_F00D, "lw");
        test_store(3'd2, 32'h0000_0301, 32'h0000_00AB, 32'h0000_0300, 4'b0010, 32'hABAB_ABAB, "sb");
        test_store(3'd1, 32'h0000_0302, 32'h0000_1234, 32'h0000_0300, 4'b1100, 32'h1234_1234, "sh");
        test_misalign(1'b0, 3'd0, 32'h0000_0102, "lw_mis");
        test_misalign(1'b1, 3'd1, 32'h0000_0101, "sh_mis");
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
